// File: rtl/cpu_isa_pkg.sv
// ISA constants shared by decode/issue and execute.
// Holds field positions, opcodes and the per-opcode register-usage decode.
package cpu_isa_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 23;
    localparam int unsigned RS1_MSB = 22;
    localparam int unsigned RS1_LSB = 20;
    localparam int unsigned RS2_MSB = 19;
    localparam int unsigned RS2_LSB = 17;
    localparam int unsigned IMM_MSB = 16;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned IMM_W   = 17;

    localparam logic [OP_W-1:0] OP_NOP   = 6'h00;
    localparam logic [OP_W-1:0] OP_ADD   = 6'h01;
    localparam logic [OP_W-1:0] OP_SUB   = 6'h02;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h03;
    localparam logic [OP_W-1:0] OP_LOAD  = 6'h04;
    localparam logic [OP_W-1:0] OP_STORE = 6'h05;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h06;
    localparam logic [OP_W-1:0] OP_HALT  = 6'h3F;

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return op inside {OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_LOAD, OP_STORE, OP_BEQ, OP_HALT};
    endfunction

    function automatic logic uses_rs1(input logic [OP_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_ADDI, OP_LOAD, OP_STORE, OP_BEQ};
    endfunction

    function automatic logic uses_rs2(input logic [OP_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_STORE, OP_BEQ};
    endfunction

    function automatic logic writes_rd(input logic [OP_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_ADDI, OP_LOAD};
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// Lookups read the registered vector only, so a clear unblocks the following cycle.
module reg_scoreboard #(
    parameter int unsigned BITS_ADDR = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    set_en,
    input  logic [BITS_ADDR-1:0]    set_addr,
    input  logic                    clr_en,
    input  logic [BITS_ADDR-1:0]    clr_addr,
    input  logic [BITS_ADDR-1:0]    addr_a,
    input  logic [BITS_ADDR-1:0]    addr_b,
    input  logic [BITS_ADDR-1:0]    addr_c,
    output logic                    pend_a,
    output logic                    pend_b,
    output logic                    pend_c,
    output logic [2**BITS_ADDR-1:0] pending
);

    logic [2**BITS_ADDR-1:0] pending_q;
    logic [2**BITS_ADDR-1:0] pending_d;

    // Set is applied after clear so a same-register collision leaves the bit set.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) pending_d[clr_addr] = 1'b0;
        if (set_en) pending_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign pend_a  = pending_q[addr_a];
    assign pend_b  = pending_q[addr_b];
    assign pend_c  = pending_q[addr_c];
    assign pending = pending_q;

endmodule

// File: rtl/instr_decode_issue.sv
// Decode/issue stage: one-entry decode slot in front of the register file, with
// RAW/WAW stall against the pending-write scoreboard, illegal-op trap and HALT drain.
module instr_decode_issue
    import cpu_isa_pkg::*;
#(
    parameter int unsigned BITS_DATA = 32,
    parameter int unsigned BITS_ADDR = 3,
    parameter int unsigned BITS_OP   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instrValid,
    output logic                 instrReady,
    input  logic [31:0]          instrWord,
    output logic                 issueValid,
    input  logic                 issueReady,
    output logic [BITS_OP-1:0]   issueOp,
    output logic [BITS_ADDR-1:0] dirrOutput1,
    output logic [BITS_ADDR-1:0] dirrOutput2,
    output logic [BITS_ADDR-1:0] dirrInput,
    output logic                 issueWrite,
    output logic [BITS_DATA-1:0] immExt,
    input  logic                 wbValid,
    input  logic [BITS_ADDR-1:0] wbDirr,
    output logic                 illegalOp,
    output logic                 halted
);

    typedef enum logic [1:0] {StEmpty, StFull, StHalted} state_e;

    state_e      state_q;
    logic [31:0] slot_q;
    logic        illegal_q;

    logic [OP_W-1:0]      op;
    logic [BITS_ADDR-1:0] rd;
    logic [BITS_ADDR-1:0] rs1;
    logic [BITS_ADDR-1:0] rs2;
    logic [IMM_W-1:0]     imm17;
    logic                 full;
    logic                 legal;
    logic                 hazard;
    logic                 issue;
    logic                 accept;
    logic                 pend_rs1;
    logic                 pend_rs2;
    logic                 pend_rd;
    logic [2**BITS_ADDR-1:0] sb;

    assign op    = slot_q[OP_MSB:OP_LSB];
    assign rd    = BITS_ADDR'(slot_q[RD_MSB:RD_LSB]);
    assign rs1   = BITS_ADDR'(slot_q[RS1_MSB:RS1_LSB]);
    assign rs2   = BITS_ADDR'(slot_q[RS2_MSB:RS2_LSB]);
    assign imm17 = slot_q[IMM_MSB:IMM_LSB];

    assign full   = (state_q == StFull);
    assign legal  = is_legal(op);
    assign hazard = (uses_rs1(op) && pend_rs1) || (uses_rs2(op) && pend_rs2)
                 || (writes_rd(op) && pend_rd);

    assign issueValid = full && legal && (op != OP_HALT) && !hazard;
    assign issue      = issueValid && issueReady;
    assign instrReady = (state_q == StEmpty) || issue;
    assign accept     = instrValid && instrReady;

    // Slot fields are only exposed while the slot holds a word.
    assign issueOp     = full ? BITS_OP'(op) : '0;
    assign dirrOutput1 = full ? rs1 : '0;
    assign dirrOutput2 = full ? rs2 : '0;
    assign dirrInput   = full ? rd : '0;
    assign issueWrite  = full && writes_rd(op);
    assign immExt      = full ? {{(BITS_DATA-IMM_W){imm17[IMM_W-1]}}, imm17} : '0;
    assign illegalOp   = illegal_q;
    assign halted      = (state_q == StHalted);

    reg_scoreboard #(
        .BITS_ADDR (BITS_ADDR)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue && writes_rd(op)),
        .set_addr (rd),
        .clr_en   (wbValid),
        .clr_addr (wbDirr),
        .addr_a   (rs1),
        .addr_b   (rs2),
        .addr_c   (rd),
        .pend_a   (pend_rs1),
        .pend_b   (pend_rs2),
        .pend_c   (pend_rd),
        .pending  (sb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StEmpty;
            slot_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        slot_q  <= instrWord;
                        state_q <= StFull;
                    end
                end
                StFull: begin
                    if (!legal) begin
                        illegal_q <= 1'b1;
                        state_q   <= StEmpty;
                    end else if (op == OP_HALT) begin
                        // HALT drains: wait for every outstanding write to retire.
                        if (sb == '0) state_q <= StHalted;
                    end else if (issue) begin
                        if (accept) slot_q  <= instrWord;
                        else        state_q <= StEmpty;
                    end
                end
                StHalted: state_q <= StHalted;
                default:  state_q <= StEmpty;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_decode_issue.sv
// Directed bench for instr_decode_issue: decode table plus hazard, illegal, HALT and reset sequences.
module tb_instr_decode_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instrWord;
    logic        issueValid;
    logic        issueReady;
    logic [5:0]  issueOp;
    logic [2:0]  dirrOutput1;
    logic [2:0]  dirrOutput2;
    logic [2:0]  dirrInput;
    logic        issueWrite;
    logic [31:0] immExt;
    logic        wbValid;
    logic [2:0]  wbDirr;
    logic        illegalOp;
    logic        halted;

    int passed = 0;
    int total  = 0;

    instr_decode_issue dut (
        .clk         (clk),
        .reset       (reset),
        .instrValid  (instrValid),
        .instrReady  (instrReady),
        .instrWord   (instrWord),
        .issueValid  (issueValid),
        .issueReady  (issueReady),
        .issueOp     (issueOp),
        .dirrOutput1 (dirrOutput1),
        .dirrOutput2 (dirrOutput2),
        .dirrInput   (dirrInput),
        .issueWrite  (issueWrite),
        .immExt      (immExt),
        .wbValid     (wbValid),
        .wbDirr      (wbDirr),
        .illegalOp   (illegalOp),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [5:0]  op;
        logic [2:0]  d1;
        logic [2:0]  d2;
        logic [2:0]  din;
        logic        wr;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [16:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{mk(6'h01, 3'd3, 3'd1, 3'd2, 17'h00000), 6'h01, 3'd1, 3'd2, 3'd3, 1'b1, 32'h0};
        vecs[1] = '{mk(6'h02, 3'd7, 3'd6, 3'd5, 17'h00010), 6'h02, 3'd6, 3'd5, 3'd7, 1'b1, 32'h10};
        vecs[2] = '{mk(6'h03, 3'd2, 3'd4, 3'd0, 17'h0FFFF), 6'h03, 3'd4, 3'd0, 3'd2, 1'b1,
                    32'h0000FFFF};
        vecs[3] = '{mk(6'h04, 3'd6, 3'd1, 3'd0, 17'h10000), 6'h04, 3'd1, 3'd0, 3'd6, 1'b1,
                    32'hFFFF0000};
        vecs[4] = '{mk(6'h05, 3'd0, 3'd3, 3'd4, 17'h00008), 6'h05, 3'd3, 3'd4, 3'd0, 1'b0, 32'h8};
        vecs[5] = '{mk(6'h06, 3'd5, 3'd7, 3'd7, 17'h1FFFF), 6'h06, 3'd7, 3'd7, 3'd5, 1'b0,
                    32'hFFFFFFFF};
        vecs[6] = '{mk(6'h00, 3'd1, 3'd2, 3'd3, 17'h00000), 6'h00, 3'd2, 3'd3, 3'd1, 1'b0, 32'h0};

        reset = 1'b1; instrValid = 1'b0; instrWord = '0; issueReady = 1'b0;
        wbValid = 1'b0; wbDirr = '0;
        tick(); tick();
        reset = 1'b0; #1;
        chk("rst_ready", instrReady, 1);
        chk("rst_valid", issueValid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegalOp, 0);
        chk("rst_dirr", {dirrOutput1, dirrOutput2, dirrInput}, 0);
        chk("rst_imm", immExt, 0);
        chk("rst_op_write", {issueOp, issueWrite}, 0);
        chk("rst_sb", dut.sb, 0);

        // Decode table: one op at a time, held one cycle by issueReady=0, then taken.
        for (int i = 0; i < 7; i++) begin
            instrWord = vecs[i].word; instrValid = 1'b1; issueReady = 1'b0;
            tick();
            instrValid = 1'b0; #1;
            chk($sformatf("v%0d_valid", i), issueValid, 1);
            chk($sformatf("v%0d_op", i), issueOp, vecs[i].op);
            chk($sformatf("v%0d_d1", i), dirrOutput1, vecs[i].d1);
            chk($sformatf("v%0d_d2", i), dirrOutput2, vecs[i].d2);
            chk($sformatf("v%0d_din", i), dirrInput, vecs[i].din);
            chk($sformatf("v%0d_wr", i), issueWrite, vecs[i].wr);
            chk($sformatf("v%0d_imm", i), immExt, vecs[i].imm);
            chk($sformatf("v%0d_ready_held", i), instrReady, 0);
            tick();
            chk($sformatf("v%0d_valid_held", i), issueValid, 1);
            chk($sformatf("v%0d_imm_held", i), immExt, vecs[i].imm);
            issueReady = 1'b1; #1;
            chk($sformatf("v%0d_ready_issue", i), instrReady, 1);
            tick();
            issueReady = 1'b0; #1;
            chk($sformatf("v%0d_empty", i), issueValid, 0);
            chk($sformatf("v%0d_sb", i), dut.sb, vecs[i].wr ? (32'd1 << vecs[i].din) : 32'd0);
            if (vecs[i].wr) begin
                wbValid = 1'b1; wbDirr = vecs[i].din;
                tick();
                wbValid = 1'b0;
            end
        end
        chk("table_sb_clean", dut.sb, 0);

        // T1/T2: ADD r3 then back-to-back ADDI r4,r3,-5 stalls on r3
        instrWord = mk(6'h01, 3'd3, 3'd1, 3'd2, 17'h0); instrValid = 1'b1; issueReady = 1'b1;
        tick();
        instrWord = mk(6'h03, 3'd4, 3'd3, 3'd0, 17'h1FFFB); #1;
        chk("t1_valid", issueValid, 1);
        chk("t1_dirr", {dirrOutput1, dirrOutput2, dirrInput}, {3'd1, 3'd2, 3'd3});
        chk("t1_write", issueWrite, 1);
        chk("t1_b2b_ready", instrReady, 1);
        tick();
        instrValid = 1'b0; #1;
        chk("t1_sb", dut.sb, 32'h08);
        chk("t2_stall", issueValid, 0);
        chk("t2_ready", instrReady, 0);
        chk("t2_imm", immExt, 32'hFFFFFFFB);
        chk("t2_din", dirrInput, 4);
        tick();
        chk("t2_stall_held", issueValid, 0);
        chk("t2_imm_held", immExt, 32'hFFFFFFFB);
        wbValid = 1'b1; wbDirr = 3'd3; #1;
        chk("t2_wb_same_cycle", issueValid, 0);
        tick();
        wbValid = 1'b0; #1;
        chk("t2_unblock", issueValid, 1);
        tick();
        chk("t2_sb", dut.sb, 32'h10);
        chk("t2_ready_after", instrReady, 1);
        wbValid = 1'b1; wbDirr = 3'd4;
        tick();
        wbValid = 1'b0;

        // T3: writeback and issue hit r5 in the same cycle; the set wins
        instrWord = mk(6'h04, 3'd5, 3'd1, 3'd0, 17'h0); instrValid = 1'b1; issueReady = 1'b0;
        tick();
        instrValid = 1'b0; #1;
        chk("t3_valid", issueValid, 1);
        issueReady = 1'b1; wbValid = 1'b1; wbDirr = 3'd5;
        tick();
        wbValid = 1'b0; issueReady = 1'b0; #1;
        chk("t3_set_wins", dut.sb, 32'h20);
        wbValid = 1'b1; wbDirr = 3'd5;
        tick();
        wbValid = 1'b0; #1;
        chk("t3_cleared", dut.sb, 0);

        // T4: illegal opcode 2A is dropped and the flag is sticky
        instrWord = mk(6'h2A, 3'd1, 3'd2, 3'd3, 17'h0); instrValid = 1'b1; issueReady = 1'b1;
        tick();
        instrValid = 1'b0; #1;
        chk("t4_no_issue", issueValid, 0);
        chk("t4_ready", instrReady, 0);
        tick();
        chk("t4_illegal", illegalOp, 1);
        chk("t4_empty_ready", instrReady, 1);
        instrWord = mk(6'h01, 3'd1, 3'd2, 3'd3, 17'h0); instrValid = 1'b1;
        tick();
        instrValid = 1'b0; #1;
        chk("t4_add_valid", issueValid, 1);
        tick();
        chk("t4_add_sb", dut.sb, 32'h02);
        chk("t4_sticky", illegalOp, 1);
        wbValid = 1'b1; wbDirr = 3'd1;
        tick();
        wbValid = 1'b0;

        // T5: HALT waits for r0 to drain, then freezes the stage
        instrWord = mk(6'h03, 3'd0, 3'd0, 3'd0, 17'h1); instrValid = 1'b1; issueReady = 1'b1;
        tick();
        instrWord = mk(6'h3F, 3'd0, 3'd0, 3'd0, 17'h0);
        tick();
        instrValid = 1'b0; #1;
        chk("t5_sb", dut.sb, 32'h01);
        chk("t5_halt_not_issued", issueValid, 0);
        chk("t5_not_halted", halted, 0);
        chk("t5_ready", instrReady, 0);
        tick(); tick();
        chk("t5_still_waiting", halted, 0);
        wbValid = 1'b1; wbDirr = 3'd0;
        tick();
        wbValid = 1'b0; #1;
        chk("t5_sb_drained", dut.sb, 0);
        tick();
        chk("t5_halted", halted, 1);
        chk("t5_halted_ready", instrReady, 0);
        instrWord = mk(6'h01, 3'd1, 3'd2, 3'd3, 17'h0); instrValid = 1'b1;
        tick(); tick();
        chk("t5_frozen_halted", halted, 1);
        chk("t5_frozen_valid", issueValid, 0);
        chk("t5_frozen_ready", instrReady, 0);
        instrValid = 1'b0;

        // T6: fill scoreboard, stall a word, then reset mid-operation
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        chk("t6_unhalt", halted, 0);
        issueReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            instrWord = mk(6'h03, 3'(i), 3'(i), 3'(i), 17'h0); instrValid = 1'b1;
            tick();
        end
        instrWord = mk(6'h01, 3'd1, 3'd2, 3'd3, 17'h0);
        tick();
        instrValid = 1'b0; #1;
        chk("t6_sb_full", dut.sb, 32'hFF);
        chk("t6_stalled", issueValid, 0);
        chk("t6_stall_ready", instrReady, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        chk("t6_sb_cleared", dut.sb, 0);
        chk("t6_valid", issueValid, 0);
        chk("t6_ready", instrReady, 1);
        chk("t6_flags", {illegalOp, halted}, 0);
        chk("t6_din", dirrInput, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
